// File: rtl/cond_ctrl_pkg.sv
// Shared types and constants for the conditional-execution control block.
// Flag layout {Q,N,Z,C,V}, ARM condition codes, controller state encoding.
package cond_ctrl_pkg;

  localparam int ALU_FLAGS_WIDTH = 5;

  localparam int FLAG_Q = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    SQUASH = 2'd2
  } state_e;

endpackage

// File: rtl/cond_ctrl_eval.sv
// Combinational ARM condition evaluator over the N,Z,C,V flags.
// Code 1111 never passes and is flagged as undefined.
module cond_eval
  import cond_ctrl_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx,
  output logic       undef
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    undef  = 1'b0;
    unique case (cond_e'(Cond))
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = ~z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: undef  = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_ctrl.sv
// Execute-stage condition gating, flag register and multi-cycle sequencing.
// Build option: COND_CTRL_SAT_FLAG_EN makes Q a sticky saturation flag.
module cond_ctrl
  import cond_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ex_valid,
  input  logic                       ex_stall,
  input  logic [3:0]                 Cond,
  input  logic [1:0]                 FlagsWrite,
  input  logic [ALU_FLAGS_WIDTH-1:0] ALUFlags,
  input  logic                       RegWriteE,
  input  logic                       MemWriteE,
  input  logic                       PCSrcE,
  input  logic                       ex_multi,
  input  logic                       mc_done,
  output logic                       RegWriteG,
  output logic                       MemWriteG,
  output logic                       PCSrcG,
  output logic [ALU_FLAGS_WIDTH-1:0] Flags,
  output logic                       stall_ex,
  output logic                       flush_fd,
  output logic                       cond_undef
);

  state_e state, state_n;

  logic       condex, undef, issue;
  logic       flags_we, lat_ld;
  logic [1:0] fw_sel;
  logic       lat_pass, lat_rw;
  logic [1:0] lat_fw;
  logic [ALU_FLAGS_WIDTH-1:0] nf;

  cond_eval u_eval (
    .Cond   (Cond),
    .Flags  (Flags[3:0]),
    .CondEx (condex),
    .undef  (undef)
  );

  assign issue      = (state == IDLE) & ex_valid & ~ex_stall;
  assign cond_undef = (state == IDLE) & ex_valid & undef;

  always_comb begin
    state_n   = state;
    RegWriteG = 1'b0;
    MemWriteG = 1'b0;
    PCSrcG    = 1'b0;
    stall_ex  = 1'b0;
    flush_fd  = 1'b0;
    flags_we  = 1'b0;
    fw_sel    = FlagsWrite;
    lat_ld    = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue && condex) begin
          if (ex_multi) begin
            state_n = BUSY;
            lat_ld  = 1'b1;
          end else begin
            RegWriteG = RegWriteE;
            MemWriteG = MemWriteE;
            PCSrcG    = PCSrcE;
            flags_we  = 1'b1;
            if (PCSrcE) begin
              flush_fd = 1'b1;
              state_n  = SQUASH;
            end
          end
        end
      end
      BUSY: begin
        if (mc_done) begin
          RegWriteG = lat_rw & lat_pass;
          flags_we  = lat_pass;
          fw_sel    = lat_fw;
          state_n   = IDLE;
        end else begin
          stall_ex = 1'b1;
        end
      end
      SQUASH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    nf = Flags;
    if (fw_sel[1]) begin
      nf[FLAG_N] = ALUFlags[FLAG_N];
      nf[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (fw_sel[0]) begin
      nf[FLAG_C] = ALUFlags[FLAG_C];
      nf[FLAG_V] = ALUFlags[FLAG_V];
    end
`ifdef COND_CTRL_SAT_FLAG_EN
    nf[FLAG_Q] = Flags[FLAG_Q] | (fw_sel[1] & ALUFlags[FLAG_Q]);
`else
    nf[FLAG_Q] = 1'b0 & ALUFlags[FLAG_Q];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      Flags    <= '0;
      lat_pass <= 1'b0;
      lat_rw   <= 1'b0;
      lat_fw   <= 2'b00;
    end else begin
      state <= state_n;
      if (flags_we)
        Flags <= nf;
      if (lat_ld) begin
        lat_pass <= condex;
        lat_rw   <= RegWriteE;
        lat_fw   <= FlagsWrite;
      end
    end
  end

endmodule

// File: doc/cond_ctrl.md
COND_CTRL -- requirements
Module: cond_ctrl

Interface
REQ-001 SHALL have one clock and one synchronous, active-high reset; no other clock or reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ex_valid  in  1  instruction present in Execute.
REQ-005 ex_stall  in  1  hazard-unit freeze of Execute.
REQ-006 Cond  in  4  instruction condition code.
REQ-007 FlagsWrite  in  2  bit1 = update N,Z; bit0 = update C,V.
REQ-008 ALUFlags  in  5  ALU flags, order {Q,N,Z,C,V}.
REQ-009 RegWriteE, MemWriteE, PCSrcE  in  1 each  ungated Execute controls.
REQ-010 ex_multi  in  1  instruction is multi-cycle (MUL/MLA).
REQ-011 mc_done  in  1  multi-cycle unit result valid this cycle.
REQ-012 RegWriteG, MemWriteG, PCSrcG  out  1 each  condition-gated controls.
REQ-013 Flags  out  5  architectural flags register, {Q,N,Z,C,V}.
REQ-014 stall_ex  out  1  block holds Execute (multi-cycle busy).
REQ-015 flush_fd  out  1  flush Fetch/Decode (taken branch).
REQ-016 cond_undef  out  1  Cond == 4'b1111 on a valid instruction.

Function
REQ-017 FSM states: IDLE, BUSY, SQUASH.
REQ-018 "Issue" = IDLE & ex_valid & ~ex_stall; CondEx is evaluated combinationally from the registered Flags only, with no forwarding.
REQ-019 CondEx table: standard ARM EQ..AL (0000-1110); 1111 SHALL give CondEx=0 and assert cond_undef that cycle.
REQ-020 On issue with CondEx=1 and ex_multi=0: gated outputs = ungated inputs; Flags updated at the clock edge per FlagsWrite; state remains IDLE.
REQ-021 On issue with CondEx=0: all gated outputs 0; Flags unchanged.
REQ-022 On issue with CondEx=1 and PCSrcE=1: PCSrcG=1 and flush_fd=1 in the same cycle; next state SQUASH.
REQ-023 SQUASH lasts exactly 1 cycle; ex_valid is ignored, gated outputs are 0, Flags are held, and the next state is IDLE.
REQ-024 On issue with CondEx=1 and ex_multi=1: no outputs that cycle; next state BUSY; latch Cond-pass, RegWriteE, and FlagsWrite.
REQ-025 In BUSY: stall_ex=1 while mc_done=0. On mc_done=1: stall_ex=0, RegWriteG=latched RegWriteE, Flags updated from ALUFlags per latched FlagsWrite, next state IDLE.
REQ-026 In BUSY, ex_stall and ex_valid are ignored; mc_done in the entry cycle itself is ignored (minimum BUSY length is 1 cycle).
REQ-027 When ex_stall=1 in IDLE: gated outputs 0, flush_fd 0, Flags held; the instruction is re-evaluated when the stall drops.
REQ-028 The flag-update rule is per field: {N,Z} when FlagsWrite[1], {C,V} when FlagsWrite[0]; both bits set updates all four.

Reset
REQ-029 Reset SHALL force state IDLE, Flags=5'b0, latched fields 0, and all outputs 0 in the following cycle.
REQ-030 Reset while in BUSY or SQUASH SHALL abandon the operation; a later mc_done is ignored in IDLE.

Configuration
REQ-031 Macro COND_CTRL_SAT_FLAG_EN defined: Q (Flags[4]) is sticky; Q |= ALUFlags[4] whenever N,Z are updated, and it is cleared only by reset.
REQ-032 Macro COND_CTRL_SAT_FLAG_EN absent: Flags[4] is constant 0 and ALUFlags[4] is ignored.

Structure
REQ-033 Shared package SHALL hold: the ALU_FLAGS_WIDTH=5 constant, flag bit indices (Q=4, N=3, Z=2, C=1, V=0), the cond-code enum, and the FSM state typedef.
REQ-034 Condition evaluation SHALL be a combinational sub-module cond_eval (Cond, Flags -> CondEx, undef); all sequential logic stays in cond_ctrl.

Verification
REQ-035 Flags=5'b00100 (Z), Cond=0000, RegWriteE=1 -> RegWriteG=1; with Cond=0001 -> RegWriteG=0, Flags unchanged.
REQ-036 Taken branch: Cond=1110, PCSrcE=1 -> PCSrcG=1 and flush_fd=1 in cycle N; in cycle N+1 ex_valid=1 with RegWriteE=1 -> RegWriteG=0; in cycle N+2 the instruction issues normally.
REQ-037 Multi-cycle: ex_multi=1, FlagsWrite=2'b10, mc_done at +3 with ALUFlags=5'b01000 -> stall_ex=1 for 3 cycles, then Flags=5'b01000 and RegWriteG=1 for one cycle.
REQ-038 Reset asserted in BUSY -> Flags=0 and stall_ex=0 next cycle; mc_done=1 afterwards causes no write.
REQ-039 Sticky Q: FlagsWrite=2'b11 with ALUFlags=5'b10000, then with ALUFlags=5'b00000 -> Flags[4]=1 with COND_CTRL_SAT_FLAG_EN defined, 0 without it.
REQ-040 Cond=1111, ex_valid=1 -> cond_undef=1, all gated outputs 0; same stimulus with ex_stall=1 -> Flags held and flush_fd=0.
